// File: rtl/ddr4_cmd_pkg.sv
// Shared definitions for the DDR4 bank-group command scheduler: strobe encodings,
// request address fields, FSM state codes and the open-row table entry.
package ddr4_cmd_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CmdNop = 4'b1111;
    localparam logic [3:0] CmdAct = 4'b0011;
    localparam logic [3:0] CmdRd  = 4'b0101;
    localparam logic [3:0] CmdWr  = 4'b0100;
    localparam logic [3:0] CmdPre = 4'b0010;

    localparam int unsigned RowMsb  = 28;
    localparam int unsigned RowLsb  = 13;
    localparam int unsigned BankMsb = 12;
    localparam int unsigned BankLsb = 10;
    localparam int unsigned ColMsb  = 9;
    localparam int unsigned ColLsb  = 0;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StPre     = 3'd1;
    localparam logic [2:0] StWaitRp  = 3'd2;
    localparam logic [2:0] StAct     = 3'd3;
    localparam logic [2:0] StWaitRcd = 3'd4;
    localparam logic [2:0] StCas     = 3'd5;
    localparam logic [2:0] StWaitCcd = 3'd6;

    typedef struct packed {
        logic        vld;
        logic [2:0]  bank;
        logic [15:0] row;
    } open_row_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ddr4_rr_arbiter.sv
// Four-way round-robin arbiter; the pointer holds the last winner and advances
// only when a grant is taken with en_i high.
module ddr4_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    input  logic       en_i,
    output logic [3:0] gnt_o,
    output logic [1:0] idx_o,
    output logic       vld_o
);

    logic [1:0] ptr_q;
    logic [1:0] cand;

    always_comb begin
        idx_o = ptr_q;
        vld_o = 1'b0;
        cand  = '0;
        // k = 4 wraps back to the previous winner, searched last
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!vld_o && req_i[cand]) begin
                idx_o = cand;
                vld_o = 1'b1;
            end
        end
    end

    assign gnt_o = vld_o ? (4'b0001 << idx_o) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd3;
        end else if (en_i && vld_o) begin
            ptr_q <= idx_o;
        end
    end

endmodule

// File: rtl/ddr4_bg_cmd_scheduler.sv
// Shares one DDR4 command bus among four bank-group requesters, keeping one open
// row per bank group and sequencing PRE/ACT/RD/WR with tRP/tRCD/tCCD spacing.
module ddr4_bg_cmd_scheduler
    import ddr4_cmd_pkg::*;
#(
    parameter int unsigned T_RP  = 4,
    parameter int unsigned T_RCD = 4,
    parameter int unsigned T_CCD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    input  logic [3:0]   req_we,
    input  logic [127:0] req_addr,
    input  logic [63:0]  req_wdata,
    output logic [3:0]   req_ready,
    output logic         cmd_done,
    output logic [1:0]   done_id,
    output logic [15:0]  ddr4_addr,
    output logic [2:0]   ddr4_ba,
    output logic [1:0]   ddr4_bg,
    output logic         ddr4_ras_n,
    output logic         ddr4_cas_n,
    output logic         ddr4_we_n,
    output logic         ddr4_cs_n,
    output logic [15:0]  ddr4_dq
);

    localparam int unsigned CntW = $clog2(max3(T_RP, T_RCD, T_CCD)) + 1;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      gid_q, gid_d;
    logic            we_q, we_d;
    logic [15:0]     row_q, row_d;
    logic [2:0]      bank_q, bank_d;
    logic [9:0]      col_q, col_d;
    logic [15:0]     wdata_q, wdata_d;
    open_row_t       tbl_q [4];
    open_row_t       tbl_d [4];

    logic [3:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [2:0]  ba_q, ba_d;
    logic [1:0]  bg_q, bg_d;
    logic [15:0] dq_q, dq_d;
    logic [3:0]  ready_q, ready_d;
    logic        done_q, done_d;
    logic [1:0]  done_id_q, done_id_d;

    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        gnt_vld;
    logic [31:0] win_addr;
    logic [15:0] win_row;
    logic [2:0]  win_bank;
    logic        win_hit;
    logic        unused_addr_hi;

    ddr4_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_valid),
        .en_i  (state_q == StIdle),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign win_addr       = req_addr[{gnt_idx, 5'b0} +: 32];
    assign win_row        = win_addr[RowMsb:RowLsb];
    assign win_bank       = win_addr[BankMsb:BankLsb];
    assign win_hit        = tbl_q[gnt_idx].vld && (tbl_q[gnt_idx].bank == win_bank) &&
                            (tbl_q[gnt_idx].row == win_row);
    assign unused_addr_hi = ^win_addr[31:29];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gid_d     = gid_q;
        we_d      = we_q;
        row_d     = row_q;
        bank_d    = bank_q;
        col_d     = col_q;
        wdata_d   = wdata_q;
        tbl_d     = tbl_q;
        cmd_d     = CmdNop;
        addr_d    = '0;
        ba_d      = '0;
        bg_d      = '0;
        dq_d      = '0;
        ready_d   = '0;
        done_d    = 1'b0;
        done_id_d = '0;
        case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    ready_d = gnt;
                    gid_d   = gnt_idx;
                    we_d    = req_we[gnt_idx];
                    row_d   = win_row;
                    bank_d  = win_bank;
                    col_d   = win_addr[ColMsb:ColLsb];
                    wdata_d = req_wdata[{gnt_idx, 4'b0} +: 16];
                    if (win_hit) begin
                        state_d = StCas;
                    end else if (tbl_q[gnt_idx].vld) begin
                        state_d = StPre;
                    end else begin
                        state_d = StAct;
                    end
                end
            end
            StPre: begin
                cmd_d             = CmdPre;
                ba_d              = tbl_q[gid_q].bank;
                bg_d              = gid_q;
                tbl_d[gid_q].vld  = 1'b0;
                cnt_d             = CntW'(T_RP - 1);
                state_d           = (T_RP == 1) ? StAct : StWaitRp;
            end
            StAct: begin
                cmd_d        = CmdAct;
                addr_d       = row_q;
                ba_d         = bank_q;
                bg_d         = gid_q;
                tbl_d[gid_q] = '{vld: 1'b1, bank: bank_q, row: row_q};
                cnt_d        = CntW'(T_RCD - 1);
                state_d      = (T_RCD == 1) ? StCas : StWaitRcd;
            end
            StCas: begin
                cmd_d     = we_q ? CmdWr : CmdRd;
                addr_d    = {6'b0, col_q};
                ba_d      = bank_q;
                bg_d      = gid_q;
                dq_d      = we_q ? wdata_q : 16'h0000;
                done_d    = 1'b1;
                done_id_d = gid_q;
                cnt_d     = CntW'(T_CCD - 1);
                state_d   = (T_CCD == 1) ? StIdle : StWaitCcd;
            end
            StWaitRp, StWaitRcd, StWaitCcd: begin
                cnt_d = cnt_q - 1'b1;
                // Leave on the cycle the count hits zero so spacing equals the parameter
                if (cnt_q == CntW'(1)) begin
                    unique case (state_q)
                        StWaitRp:  state_d = StAct;
                        StWaitRcd: state_d = StCas;
                        default:   state_d = StIdle;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gid_q     <= '0;
            we_q      <= 1'b0;
            row_q     <= '0;
            bank_q    <= '0;
            col_q     <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                tbl_q[i] <= '0;
            end
            cmd_q     <= CmdNop;
            addr_q    <= '0;
            ba_q      <= '0;
            bg_q      <= '0;
            dq_q      <= '0;
            ready_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gid_q     <= gid_d;
            we_q      <= we_d;
            row_q     <= row_d;
            bank_q    <= bank_d;
            col_q     <= col_d;
            wdata_q   <= wdata_d;
            tbl_q     <= tbl_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
            bg_q      <= bg_d;
            dq_q      <= dq_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n} = cmd_q;
    assign ddr4_addr = addr_q;
    assign ddr4_ba   = ba_q;
    assign ddr4_bg   = bg_q;
    assign ddr4_dq   = dq_q;
    assign req_ready = ready_q;
    assign cmd_done  = done_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_ddr4_bg_cmd_scheduler.sv
// Scoreboard bench: the driver predicts each command bus transaction and grant as it
// issues requests; a negedge monitor pops and compares every observed cycle.
module tb_ddr4_bg_cmd_scheduler;

    localparam int T_RP  = 3;
    localparam int T_RCD = 4;
    localparam int T_CCD = 2;

    localparam logic [3:0] NOP = 4'b1111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [43:0] IDLE_VEC = {NOP, 40'h0};

    typedef struct {
        int          cyc;
        logic [43:0] vec;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_we = '0;
    logic [127:0] req_addr = '0;
    logic [63:0]  req_wdata = '0;
    logic [3:0]   req_ready;
    logic         cmd_done;
    logic [1:0]   done_id;
    logic [15:0]  ddr4_addr;
    logic [2:0]   ddr4_ba;
    logic [1:0]   ddr4_bg;
    logic         ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_cs_n;
    logic [15:0]  ddr4_dq;

    ddr4_bg_cmd_scheduler #(
        .T_RP  (T_RP),
        .T_RCD (T_RCD),
        .T_CCD (T_CCD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .cmd_done   (cmd_done),
        .done_id    (done_id),
        .ddr4_addr  (ddr4_addr),
        .ddr4_ba    (ddr4_ba),
        .ddr4_bg    (ddr4_bg),
        .ddr4_ras_n (ddr4_ras_n),
        .ddr4_cas_n (ddr4_cas_n),
        .ddr4_we_n  (ddr4_we_n),
        .ddr4_cs_n  (ddr4_cs_n),
        .ddr4_dq    (ddr4_dq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    exp_t       sb_q[$];
    logic [3:0] gq[$];

    // Reference model state
    logic        m_vld  [4];
    logic [2:0]  m_bank [4];
    logic [15:0] m_row  [4];
    int          m_rr;
    int          last_cas;
    bit          chained;

    bit          s_we   [4];
    logic [15:0] s_row  [4];
    logic [2:0]  s_bank [4];
    logic [9:0]  s_col  [4];
    logic [15:0] s_wd   [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [43:0] obs_vec();
        return {ddr4_cs_n, ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_addr, ddr4_ba, ddr4_bg,
                ddr4_dq, cmd_done, done_id};
    endfunction

    function automatic logic [43:0] mk(input logic [3:0] c, input logic [15:0] a,
                                       input logic [2:0] ba, input int bg, input logic [15:0] dq,
                                       input logic dn, input int id);
        return {c, a, ba, 2'(bg), dq, dn, 2'(id)};
    endfunction

    function automatic int rr_pick(input logic [3:0] mask, input int rr);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(rr + k) % 4]) return (rr + k) % 4;
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        logic [43:0] obs;
        exp_t e;
        obs = obs_vec();
        if (obs[43:40] != NOP) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_cmd", obs, IDLE_VEC);
            end else begin
                e = sb_q.pop_front();
                check_eq("cmd", obs, e.vec);
                check_eq("cmd_cycle", cyc, e.cyc);
            end
        end else begin
            check_eq("nop_cycle", obs, IDLE_VEC);
        end
        if (req_ready != 4'b0) begin
            if (gq.size() == 0) check_eq("ready_extra", req_ready, 4'b0);
            else check_eq("ready", req_ready, gq.pop_front());
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i]  = 1'b0;
            m_bank[i] = '0;
            m_row[i]  = '0;
        end
        m_rr    = 3;
        chained = 1'b0;
    endtask

    task automatic set_slot(input int g, input bit we, input logic [15:0] row,
                            input logic [2:0] bank, input logic [9:0] col, input logic [15:0] wd);
        s_we[g] = we; s_row[g] = row; s_bank[g] = bank; s_col[g] = col; s_wd[g] = wd;
        req_we[g]             = we;
        req_addr[g*32 +: 32]  = {3'b000, row, bank, col};
        req_wdata[g*16 +: 16] = wd;
    endtask

    task automatic expect_seq(input int g, input int r);
        exp_t e;
        int t;
        t = r + 1;
        if (!(m_vld[g] && m_bank[g] == s_bank[g] && m_row[g] == s_row[g])) begin
            if (m_vld[g]) begin
                e.cyc = t; e.vec = mk(PRE, 16'h0, m_bank[g], g, 16'h0, 1'b0, 0);
                sb_q.push_back(e);
                t += T_RP;
            end
            e.cyc = t; e.vec = mk(ACT, s_row[g], s_bank[g], g, 16'h0, 1'b0, 0);
            sb_q.push_back(e);
            t += T_RCD;
            m_vld[g] = 1'b1; m_bank[g] = s_bank[g]; m_row[g] = s_row[g];
        end
        e.cyc = t;
        e.vec = mk(s_we[g] ? WR : RD, {6'b0, s_col[g]}, s_bank[g], g,
                   s_we[g] ? s_wd[g] : 16'h0, 1'b1, g);
        sb_q.push_back(e);
        last_cas = t;
    endtask

    task automatic wait_ready(output int r);
        r = -1;
        for (int i = 0; i < 200 && r < 0; i++) begin
            @(negedge clk);
            if (req_ready != 4'b0) r = cyc;
        end
        if (r < 0) check_eq("ready_timeout", 0, 1);
    endtask

    // Grant prediction, wait for the accept pulse, then predict the command sequence
    task automatic take_grant(input logic [3:0] mask, output int r);
        int w;
        w = rr_pick(mask, m_rr);
        gq.push_back(4'b0001 << w);
        wait_ready(r);
        if (r < 0) r = cyc;
        if (chained) check_eq("grant_gap", r, last_cas + T_CCD);
        m_rr = w;
        expect_seq(w, r);
        chained = 1'b1;
    endtask

    task automatic do_req(input int g, input bit we, input logic [15:0] row,
                          input logic [2:0] bank, input logic [9:0] col, input logic [15:0] wd);
        int r;
        set_slot(g, we, row, bank, col, wd);
        req_valid[g] = 1'b1;
        take_grant(4'b0001 << g, r);
        req_valid[g] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", sb_q.size(), 0);
        repeat (T_CCD + 1) @(negedge clk);
        chained = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        gq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("reset_cmd", obs_vec(), IDLE_VEC);
        check_eq("reset_ready", req_ready, 4'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, row hit write, conflict miss, then back-to-back hits
        do_req(0, 1'b0, 16'h0012, 3'd2, 10'h005, 16'h0000);
        do_req(0, 1'b1, 16'h0012, 3'd2, 10'h005, 16'hBEEF);
        do_req(0, 1'b1, 16'h0013, 3'd2, 10'h007, 16'h1234);
        do_req(0, 1'b0, 16'h0013, 3'd2, 10'h008, 16'h0000);
        do_req(0, 1'b1, 16'h0013, 3'd2, 10'h3FF, 16'hA5A5);
        // Same row in another bank group is tracked separately; same row, other bank misses
        do_req(2, 1'b0, 16'h0013, 3'd2, 10'h001, 16'h0000);
        do_req(2, 1'b0, 16'h0013, 3'd6, 10'h002, 16'h0000);
        wait_drain();

        // Abort while waiting tRCD; table must be forgotten
        set_slot(1, 1'b0, 16'hFFFF, 3'd5, 10'h123, 16'h0000);
        req_valid[1] = 1'b1;
        take_grant(4'b0010, r);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        gq.delete();
        model_reset();
        check_eq("abort_cmd", obs_vec(), IDLE_VEC);
        check_eq("abort_ready", req_ready, 4'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(1, 1'b0, 16'hFFFF, 3'd5, 10'h123, 16'h0000);
        wait_drain();

        // All four requesting: fresh pointer gives 0,1,2,3,0
        do_reset();
        set_slot(0, 1'b0, 16'h0012, 3'd2, 10'h001, 16'h0000);
        set_slot(1, 1'b1, 16'h0040, 3'd1, 10'h002, 16'h1111);
        set_slot(2, 1'b0, 16'h0050, 3'd3, 10'h003, 16'h0000);
        set_slot(3, 1'b1, 16'h0060, 3'd7, 10'h004, 16'h3333);
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) take_grant(4'b1111, r);
        req_valid = 4'b0000;
        wait_drain();

        check_eq("sb_left", sb_q.size() + gq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ddr4_bg_cmd_scheduler.md
Name: ddr4_bg_cmd_scheduler

Overview:
- Shares one DDR4 command/address bus between four bank-group requesters (index = bank group 0..3), granting them round-robin.
- Tracks one open row per bank group and issues the needed PRE/ACT/RD/WR sequence with tRP/tRCD/tCCD spacing.
- Sits between the per-bank-group request logic and the DDR4 pins, replacing direct multi-driver hookup of the command bus.

Parameters:
- T_RP, 4, cycles from PRE to next ACT (min 1)
- T_RCD, 4, cycles from ACT to RD/WR (min 1)
- T_CCD, 4, cycles from RD/WR to next command of any kind (min 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  4  request pending, bit i = bank group i
- req_we  in  4  1=write, 0=read, per requester
- req_addr  in  128  4x32 packed, slot i = bits [32i+31:32i]; [28:13] row, [12:10] bank, [9:0] column
- req_wdata  in  64  4x16 packed write data
- req_ready  out  4  one-cycle accept pulse to granted requester
- cmd_done  out  1  pulse on RD/WR issue cycle
- done_id  out  2  bank group of the completed access, valid with cmd_done
- ddr4_addr  out  16  row on ACT; {6'b0,col} on RD/WR; 16'b0 on PRE (A10=0, single bank)
- ddr4_ba  out  3  bank
- ddr4_bg  out  2  bank group
- ddr4_ras_n, ddr4_cas_n, ddr4_we_n, ddr4_cs_n  out  1 each  command strobes
- ddr4_dq  out  16  write data on WR cycle, else 16'b0

Behaviour:
- Commands (cs_n,ras_n,cas_n,we_n): NOP=1111, ACT=0011, RD=0101, WR=0100, PRE=0010. All outputs registered.
- Reset: state IDLE; strobes NOP; addr/ba/bg/dq=0; req_ready=0; cmd_done=0; done_id=0; all open-row entries invalid; rr pointer=3, so bank group 0 wins first.
- Open-row table: per bank group {vld, bank[2:0], row[15:0]}.
- FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CCD.
- IDLE: if any req_valid, grant the first set bit searching from rr+1 (mod 4). Same cycle: latch we/addr/wdata of the winner, pulse req_ready[i], set rr=i.
- Next state after grant:
  - hit (vld & bank & row match) -> CAS
  - miss with vld=1 -> PRE
  - vld=0 -> ACT
- PRE: drive PRE with ba = table bank, bg=i; clear vld; load wait counter = T_RP-1; -> WAIT_RP, or ACT directly if T_RP=1.
- ACT: drive ACT with row/bank; write the table entry; counter = T_RCD-1; -> WAIT_RCD (or CAS if T_RCD=1).
- CAS: drive RD or WR; for WR, ddr4_dq = wdata. Pulse cmd_done with done_id=i. Counter = T_CCD-1; -> WAIT_CCD (or IDLE if T_CCD=1).
- WAIT_*: NOP; decrement the counter; leave the state when counter reaches 0.
- Latency: hit = grant + 1 cycle to CAS. Cold miss = 1+T_RCD cycles. Conflict miss = 1+T_RP+T_RCD cycles.
- No new grant outside IDLE; req_valid must stay asserted until req_ready. Requesters not granted keep waiting, so no starvation under round-robin.
- Rows stay open after access (open-page policy). No auto-precharge, no refresh.
- Grant and release are never simultaneous; a single outstanding command at all times.
- Counter width: clog2 of max(T_RP,T_RCD,T_CCD) plus 1.
- Reset asserted mid-sequence aborts immediately to reset values; any partially opened row is forgotten.

Decomposition:
- Shared package ddr4_cmd_pkg: command encodings (NOP/ACT/RD/WR/PRE 4-bit strobe constants), address-field bit positions, FSM state encodings.
- Natural sub-module ddr4_rr_arbiter: 4-way round-robin with pointer update on grant enable.

Test Plan:
- Reset then req_valid=0001, rd, addr row 0x0012 bank 2 col 0x005 -> ACT (bg0, ba2, addr 0x0012) on cycle 2; RD on cycle 2+T_RCD with addr 0x0005; cmd_done, done_id=0.
- Repeat the same address as a write, wdata 0xBEEF -> no ACT; WR one cycle after req_ready with ddr4_dq=0xBEEF (row hit).
- Same bank group, row 0x0013 -> PRE (ba2, addr 0), ACT after T_RP cycles, WR after T_RCD more cycles.
- req_valid=1111 held -> grants in order 0,1,2,3,0, each spaced by the full sequence plus T_CCD; exactly one req_ready pulse per grant.
- Between two hits -> consecutive CAS commands exactly T_CCD+1 cycles apart, NOPs in between.
- Assert rst_n=0 in WAIT_RCD -> outputs NOP/zero immediately; after release, the same address re-issues ACT (table cleared).
